gray_pos_tracker: RTL
=====================

// Module: gray_pos_tracker
// PURPOSE
//  Tracks a Gray-coded absolute position input (rotary/linear encoder or cross-domain counter).
//  Synchronises and debounces the input, then converts it to binary with a prefix-XOR.
//  Sequences acquisition, single-step tracking and fault handling.
//  Reports position, direction, step strobes and wrap count to downstream control logic.
// PARAMETERS
//  WIDTH          4  width of gray_in / pos_bin, >=2
//  STABLE_CYCLES  2  consecutive cycles a sampled code must hold before acceptance, >=1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  en         in   1      tracking enable
//  gray_in    in   WIDTH  Gray-coded position, may be asynchronous to clk
//  clear_err  in   1      leave FAULT and re-acquire
//  pos_bin    out  WIDTH  last accepted position, binary
//  pos_valid  out  1      pos_bin is trustworthy
//  dir        out  1      direction of last step: 1 = up, 0 = down
//  step_pulse out  1      one-cycle strobe when pos_bin changes by a step
//  wrap_cnt   out  8      revolution counter, modulo 256
//  err        out  1      sticky fault flag
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pos_bin=0, pos_valid=0, dir=0, step_pulse=0, wrap_cnt=0, err=0.
//  - Sample/sync flops and stability counter cleared; state=IDLE.
//  Input path: gray_in -> [sync, see CONFIGURATION] -> g_q (registered every cycle).
//  - b = binary of g_q: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
//  Acceptance:
//  - A code is accepted on the edge at which it has been on g_q for STABLE_CYCLES consecutive cycles.
//  - Any change of g_q restarts the count.
//  - Outputs update on the acceptance edge.
//  - Each distinct stable code is accepted once.
//  FSM states: IDLE, ACQUIRE, TRACK, FAULT.
//  - IDLE: en=1 -> ACQUIRE.
//  - ACQUIRE: on acceptance, pos_bin<=b and pos_valid<=1, no step_pulse; -> TRACK.
//  - TRACK: on acceptance, d = (b - pos_bin) mod 2^WIDTH.
//    - d=1: pos_bin<=b, dir<=1, step_pulse=1; if pos_bin was all-ones, wrap_cnt+1.
//    - d=all-ones: pos_bin<=b, dir<=0, step_pulse=1; if pos_bin was 0, wrap_cnt-1.
//    - d=0: no change.
//    - otherwise (multi-step jump): err<=1, pos_valid<=0, pos_bin holds last good value; -> FAULT.
//  - FAULT: err stays 1 and ignores gray_in. clear_err=1 -> err<=0, -> ACQUIRE.
//  - Any state with en=0 -> IDLE next edge.
//    - pos_valid<=0 and step_pulse=0; pos_bin, dir, wrap_cnt, err hold.
//    - The stability counter is cleared.
//    - en=0 with clear_err=1 in FAULT: IDLE wins and err is cleared.
//    - From IDLE with err=1, en=1 -> ACQUIRE.
//  step_pulse is never high for two consecutive cycles; wrap_cnt wraps silently 255<->0.
//  Reset mid-operation: outputs go to reset values immediately, not waiting for clk.
// CONFIGURATION
//  GRAY_SYNC_EN defined:
//  - 2-flop synchroniser ahead of g_q.
//  - gray_in change to outputs = 3+STABLE_CYCLES edges.
//  GRAY_SYNC_EN undefined:
//  - gray_in sampled directly into g_q; gray_in must be synchronous to clk.
//  - Latency = 1+STABLE_CYCLES edges.
//  Functional behaviour is otherwise identical.
// TESTING (WIDTH=4, STABLE_CYCLES=2, both macro settings)
//  1. Reset release, en=1, gray_in=0000 held
//     -> pos_valid=1, pos_bin=0, no step_pulse, err=0, wrap_cnt=0.
//  2. gray_in 0000->0001->0011->0010->0110, each held 4 cycles
//     -> pos_bin 1,2,3,4; dir=1; exactly 4 step_pulses, each at the latency above.
//  3. From 0000 apply 1000 (bin 15) -> pos_bin=15, dir=0, wrap_cnt=8'hFF.
//     Then 0000 -> pos_bin=0, dir=1, wrap_cnt=8'h00.
//  4. From 0000 apply 0011 (bin 2) -> err=1, pos_valid=0, pos_bin=0.
//     Then clear_err=1 for 1 cycle -> pos_bin=2, pos_valid=1, err=0, no step_pulse.
//  5. Glitch: 0001 for 1 cycle then back to 0000 -> no step_pulse, pos_bin=0.
//     Then en=0 -> pos_valid=0 next edge.
//  6. rst_n=0 mid-TRACK (pos_bin=4, wrap_cnt=3)
//     -> all outputs 0 before the next clk edge; re-acquire after release.

Source files
------------

// File: rtl/gray_pos_tracker.sv
// Gray-coded position tracker: synchronise, debounce, Gray->binary, step/wrap/fault sequencing.
// Optional macro GRAY_SYNC_EN adds a 2-flop synchroniser ahead of the sample register.
module gray_pos_tracker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] pos_bin,
    output logic             pos_valid,
    output logic             dir,
    output logic             step_pulse,
    output logic [7:0]       wrap_cnt,
    output logic             err
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             acc_hold;
    logic             accept;

`ifdef GRAY_SYNC_EN
    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;

    // Two-flop synchroniser for an input asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= gray_in;
            sync_2 <= sync_1;
        end
    end
    assign g_d = sync_2;
`else
    assign g_d = gray_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) g_q <= '0;
        else        g_q <= g_d;
    end

    // Prefix-XOR Gray to binary: b[i] is the XOR of g_q[WIDTH-1:i]
    always_comb begin
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g_q >> i);
        end
    end

    assign d = b - pos_bin;

    // A pending acceptance is held off one cycle if a step strobe is still high
    assign acc_hold = (cnt == CNT_ACC) && step_pulse;
    assign accept   = (cnt == CNT_ACC) && !step_pulse;
    assign cnt_clr  = !en || (state == S_IDLE) || (state == S_FAULT);

    // Stability counter: cycles the current g_q code has been held, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr || (g_d != g_q)) begin
            cnt <= '0;
        end else if ((cnt != CNT_MAX) && !acc_hold) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pos_bin    <= '0;
            pos_valid  <= 1'b0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            wrap_cnt   <= 8'd0;
            err        <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (!en) begin
                state     <= S_IDLE;
                pos_valid <= 1'b0;
                if ((state == S_FAULT) && clear_err) err <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_ACQUIRE;
                    S_ACQUIRE: begin
                        if (accept) begin
                            pos_bin   <= b;
                            pos_valid <= 1'b1;
                            state     <= S_TRACK;
                        end
                    end
                    S_TRACK: begin
                        if (accept) begin
                            if (d == WIDTH'(1)) begin
                                pos_bin    <= b;
                                dir        <= 1'b1;
                                step_pulse <= 1'b1;
                                if (pos_bin == ONES) wrap_cnt <= wrap_cnt + 8'd1;
                            end else if (d == ONES) begin
                                pos_bin    <= b;
                                dir        <= 1'b0;
                                step_pulse <= 1'b1;
                                if (pos_bin == '0) wrap_cnt <= wrap_cnt - 8'd1;
                            end else if (d != '0) begin
                                // Multi-step jump: keep last good position, flag fault
                                err       <= 1'b1;
                                pos_valid <= 1'b0;
                                state     <= S_FAULT;
                            end
                        end
                    end
                    S_FAULT: begin
                        if (clear_err) begin
                            err   <= 1'b0;
                            state <= S_ACQUIRE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
